// File: rtl/cache_arbiter.sv
// Two-client line arbiter: instruction and data caches share one physical memory port.
// Round-robin between contenders, one transaction at a time, with request fields latched at grant.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        grant
);

  // Encoding doubles as the grant output value.
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] SERVE_I = 2'b01;
  localparam logic [1:0] SERVE_D = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic              live_q, live_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic d_req;
  logic serving;
  logic owner_req;
  logic resp_ok;

  // Owner request tracking and qualified completion.
  always_comb begin
    d_req   = d_read | d_write;
    serving = 1'b0;
    owner_req = 1'b0;
    case (state_q)
      SERVE_I: begin
        serving   = 1'b1;
        owner_req = i_read;
      end
      SERVE_D: begin
        serving   = 1'b1;
        owner_req = d_req;
      end
      default: begin
        serving   = 1'b0;
        owner_req = 1'b0;
      end
    endcase
    // An owner that let go of its request at any point gets no response.
    resp_ok = serving & pmem_resp & live_q & owner_req;
  end

  // Arbitration and transaction sequencing.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    live_d       = live_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_read || !last_owner_q)) begin
          state_d = SERVE_D;
          addr_d  = d_addr;
          we_d    = d_write;
          wdata_d = d_wdata;
          live_d  = 1'b1;
        end else if (i_read) begin
          state_d = SERVE_I;
          addr_d  = i_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          live_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        live_d = live_q & owner_req;
        if (pmem_resp) begin
          state_d      = IDLE;
          last_owner_d = (state_q == SERVE_D);
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched transaction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b0;
      we_q         <= 1'b0;
      live_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      live_q       <= live_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign grant      = state_q;
  assign pmem_read  = serving & ~we_q;
  assign pmem_write = serving & we_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;

  assign i_resp  = resp_ok & (state_q == SERVE_I);
  assign d_resp  = resp_ok & (state_q == SERVE_D);
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scenario tasks plus randomized rounds checked against a transaction-level arbitration model.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [1:0]    grant;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [LW-1:0] line;
    rst = 1'b0;
    clear_inputs();
    i_read = 1'b1; i_addr = 32'h0000_0040;
    #1;
    chk_cnt++; if ({grant, pmem_read, pmem_write, i_resp, d_resp} !== 6'b0) $display("FAIL reset_ctl got %b want 0", {grant, pmem_read, pmem_write, i_resp, d_resp}); else pass_cnt++;
    chk_cnt++; if (pmem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", pmem_addr); else pass_cnt++;
    chk_cnt++; if (pmem_wdata !== '0) $display("FAIL reset_wdata got %h want 0", pmem_wdata); else pass_cnt++;
    chk_cnt++; if ((i_rdata | d_rdata) !== '0) $display("FAIL reset_rdata got %h want 0", i_rdata | d_rdata); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (grant !== 2'b00) $display("FAIL reset_hold_grant got %b want 00", grant); else pass_cnt++;
    rst = 1'b1;
    tick();
    chk_cnt++; if (grant !== 2'b01 || pmem_addr !== 32'h40) $display("FAIL reset_held_req got %b/%h want 01/40", grant, pmem_addr); else pass_cnt++;
    line = rand_line();
    pmem_resp = 1'b1; pmem_rdata = line;
    #1;
    chk_cnt++; if (i_resp !== 1'b1 || i_rdata !== line) $display("FAIL reset_held_resp got %b want 1", i_resp); else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    chk_cnt++; if (grant !== 2'b00) $display("FAIL reset_back_idle got %b want 00", grant); else pass_cnt++;
  endtask

  task automatic test_i_read();
    int rd_hi = 0;
    int ir_cnt = 0;
    i_read = 1'b1; i_addr = 32'h0000_0060;
    tick();
    for (int c = 1; c <= 3; c++) begin
      pmem_resp  = (c == 3);
      pmem_rdata = (c == 3) ? {32{8'hA5}} : '0;
      #1;
      rd_hi  += int'(pmem_read);
      ir_cnt += int'(i_resp);
      chk_cnt++; if (pmem_addr !== 32'h60 || d_resp !== 1'b0) $display("FAIL iread_cyc%0d got addr %h d_resp %b want 60/0", c, pmem_addr, d_resp); else pass_cnt++;
      if (c == 3) begin
        chk_cnt++; if (i_rdata !== {32{8'hA5}}) $display("FAIL iread_rdata got %h want a5..a5", i_rdata); else pass_cnt++;
      end
      tick();
    end
    i_read = 1'b0; pmem_resp = 1'b0;
    #1;
    chk_cnt++; if (rd_hi !== 3) $display("FAIL iread_strobe_cycles got %0d want 3", rd_hi); else pass_cnt++;
    chk_cnt++; if (ir_cnt !== 1) $display("FAIL iread_resp_pulses got %0d want 1", ir_cnt); else pass_cnt++;
    chk_cnt++; if (pmem_read !== 1'b0 || grant !== 2'b00) $display("FAIL iread_end got %b/%b want 0/00", pmem_read, grant); else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [LW-1:0] wd, line;
    do_reset();
    wd = rand_line(); line = rand_line();
    i_read = 1'b1; i_addr = 32'h0000_1000;
    d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = wd;
    tick();
    chk_cnt++; if (grant !== 2'b10 || pmem_write !== 1'b1 || pmem_read !== 1'b0) $display("FAIL cont_d_first got %b w%b r%b want 10 w1 r0", grant, pmem_write, pmem_read); else pass_cnt++;
    chk_cnt++; if (pmem_addr !== 32'h2000 || pmem_wdata !== wd) $display("FAIL cont_d_payload got %h want 2000", pmem_addr); else pass_cnt++;
    tick();
    pmem_resp = 1'b1;
    #1;
    chk_cnt++; if ({d_resp, i_resp} !== 2'b10) $display("FAIL cont_d_resp got %b want 10", {d_resp, i_resp}); else pass_cnt++;
    tick();
    d_write = 1'b0; pmem_resp = 1'b0;
    #1;
    chk_cnt++; if (grant !== 2'b00) $display("FAIL cont_gap got %b want 00", grant); else pass_cnt++;
    tick();
    chk_cnt++; if (grant !== 2'b01 || pmem_read !== 1'b1 || pmem_addr !== 32'h1000) $display("FAIL cont_i_second got %b r%b %h want 01 r1 1000", grant, pmem_read, pmem_addr); else pass_cnt++;
    pmem_resp = 1'b1; pmem_rdata = line;
    #1;
    chk_cnt++; if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== line) $display("FAIL cont_i_resp got %b%b want 10", i_resp, d_resp); else pass_cnt++;
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [3];
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10;
    do_reset();
    i_read = 1'b1; i_addr = 32'h0000_0a00;
    d_read = 1'b1; d_addr = 32'h0000_0b00;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk_cnt++; if (grant !== exp_g[r]) $display("FAIL b2b_grant%0d got %b want %b", r, grant, exp_g[r]); else pass_cnt++;
      pmem_resp = 1'b1;
      #1;
      chk_cnt++; if ({d_resp, i_resp} !== exp_g[r]) $display("FAIL b2b_resp%0d got %b want %b", r, {d_resp, i_resp}, exp_g[r]); else pass_cnt++;
      tick();
      pmem_resp = 1'b0;
      #1;
      chk_cnt++; if (grant !== 2'b00) $display("FAIL b2b_gap%0d got %b want 00", r, grant); else pass_cnt++;
    end
    clear_inputs();
  endtask

  task automatic test_rw_both();
    int dr_cnt = 0;
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0100; d_wdata = rand_line();
    tick();
    for (int c = 1; c <= 2; c++) begin
      pmem_resp = (c == 2);
      #1;
      dr_cnt += int'(d_resp);
      chk_cnt++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h100) $display("FAIL rw_cyc%0d got w%b r%b %h want w1 r0 100", c, pmem_write, pmem_read, pmem_addr); else pass_cnt++;
      tick();
    end
    d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    #1;
    chk_cnt++; if (dr_cnt !== 1 || d_resp !== 1'b0) $display("FAIL rw_resp_pulses got %0d want 1", dr_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0200; d_wdata = rand_line();
    tick();
    #1;
    chk_cnt++; if (pmem_write !== 1'b1 || grant !== 2'b10) $display("FAIL mid_pre got w%b %b want w1 10", pmem_write, grant); else pass_cnt++;
    tick();
    rst = 1'b0;
    #1;
    chk_cnt++; if ({pmem_write, pmem_read, grant} !== 4'b0) $display("FAIL mid_async got %b want 0000", {pmem_write, pmem_read, grant}); else pass_cnt++;
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk_cnt++; if (grant !== 2'b00) $display("FAIL mid_release got %b want 00", grant); else pass_cnt++;
    tick();
    chk_cnt++; if (grant !== 2'b10 || pmem_write !== 1'b1) $display("FAIL mid_restart got %b w%b want 10 w1", grant, pmem_write); else pass_cnt++;
    pmem_resp = 1'b1;
    #1;
    chk_cnt++; if (d_resp !== 1'b1) $display("FAIL mid_resp got %b want 1", d_resp); else pass_cnt++;
    tick();
    clear_inputs();
  endtask

  task automatic test_drop();
    i_read = 1'b1; i_addr = 32'h0000_0300;
    tick();
    chk_cnt++; if (pmem_read !== 1'b1 || grant !== 2'b01) $display("FAIL drop_start got r%b %b want r1 01", pmem_read, grant); else pass_cnt++;
    i_read = 1'b0;
    tick();
    chk_cnt++; if (pmem_read !== 1'b1 || grant !== 2'b01) $display("FAIL drop_hold got r%b %b want r1 01", pmem_read, grant); else pass_cnt++;
    tick();
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    #1;
    chk_cnt++; if (pmem_read !== 1'b1 || i_resp !== 1'b0 || i_rdata !== '0) $display("FAIL drop_resp got r%b i_resp %b want r1 0", pmem_read, i_resp); else pass_cnt++;
    tick();
    pmem_resp = 1'b0;
    #1;
    chk_cnt++; if (grant !== 2'b00 || pmem_read !== 1'b0) $display("FAIL drop_end got %b want 00", grant); else pass_cnt++;
  endtask

  task automatic test_idle_resp();
    for (int c = 0; c < 3; c++) begin
      pmem_resp = 1'b1; pmem_rdata = rand_line();
      #1;
      chk_cnt++; if ({grant, i_resp, d_resp} !== 4'b0 || (i_rdata | d_rdata) !== '0) $display("FAIL idle_resp%0d got %b want 0000", c, {grant, i_resp, d_resp}); else pass_cnt++;
      tick();
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_random();
    bit last_was_d;
    do_reset();
    last_was_d = 1'b0;
    for (int n = 0; n < 60; n++) begin
      bit ir, dr, dw, dreq, win_d, exp_wr, drop, exp_resp;
      int lat, drop_c;
      logic [AW-1:0] ia, da, exp_addr;
      logic [LW-1:0] wd, line;
      logic [1:0] exp_grant;
      ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1)); dw = 1'($urandom_range(0, 1));
      ia = $urandom; da = $urandom; wd = rand_line();
      lat = $urandom_range(1, 4);
      drop = (lat > 1) && ($urandom_range(0, 3) == 0);
      drop_c = (lat > 1) ? $urandom_range(1, lat - 1) : 0;
      dreq = dr | dw;
      i_read = ir; i_addr = ia; d_read = dr; d_write = dw; d_addr = da; d_wdata = wd;
      if (!ir && !dreq) begin
        pmem_resp = 1'($urandom_range(0, 1));
        #1;
        chk_cnt++; if ({grant, i_resp, d_resp} !== 4'b0) $display("FAIL rnd%0d_noreq got %b want 0000", n, {grant, i_resp, d_resp}); else pass_cnt++;
        tick();
        pmem_resp = 1'b0;
      end else begin
        // Sole requester wins; under contention, whoever was not served last.
        win_d     = (ir && dreq) ? !last_was_d : dreq;
        exp_wr    = win_d && dw;
        exp_addr  = win_d ? da : ia;
        exp_grant = win_d ? 2'b10 : 2'b01;
        exp_resp  = !drop;
        line      = rand_line();
        tick();
        i_addr = $urandom; d_addr = $urandom; d_wdata = rand_line();
        for (int c = 1; c <= lat; c++) begin
          if (drop && c == drop_c) begin
            if (win_d) begin d_read = 1'b0; d_write = 1'b0; end
            else i_read = 1'b0;
          end
          pmem_resp  = (c == lat);
          pmem_rdata = (c == lat) ? line : rand_line();
          #1;
          chk_cnt++; if (grant !== exp_grant) $display("FAIL rnd%0d_grant got %b want %b", n, grant, exp_grant); else pass_cnt++;
          chk_cnt++; if ({pmem_read, pmem_write} !== {!exp_wr, exp_wr}) $display("FAIL rnd%0d_strobe got %b want %b", n, {pmem_read, pmem_write}, {!exp_wr, exp_wr}); else pass_cnt++;
          chk_cnt++; if (pmem_addr !== exp_addr) $display("FAIL rnd%0d_addr got %h want %h", n, pmem_addr, exp_addr); else pass_cnt++;
          if (exp_wr) begin
            chk_cnt++; if (pmem_wdata !== wd) $display("FAIL rnd%0d_wdata got %h want %h", n, pmem_wdata, wd); else pass_cnt++;
          end
          if (c == lat) begin
            chk_cnt++; if ({i_resp, d_resp} !== {exp_resp && !win_d, exp_resp && win_d}) $display("FAIL rnd%0d_resp got %b want %b", n, {i_resp, d_resp}, {exp_resp && !win_d, exp_resp && win_d}); else pass_cnt++;
            chk_cnt++; if (i_rdata !== ((exp_resp && !win_d) ? line : '0) || d_rdata !== ((exp_resp && win_d) ? line : '0)) $display("FAIL rnd%0d_rdata got %h / %h", n, i_rdata, d_rdata); else pass_cnt++;
          end else begin
            chk_cnt++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL rnd%0d_early_resp got %b want 00", n, {i_resp, d_resp}); else pass_cnt++;
          end
          tick();
        end
        last_was_d = win_d;
        clear_inputs();
        #1;
        chk_cnt++; if (grant !== 2'b00) $display("FAIL rnd%0d_gap got %b want 00", n, grant); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_contention();
    test_back_to_back();
    test_rw_both();
    test_reset_midflight();
    test_drop();
    test_idle_resp();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
